// File: rtl/intra_pred_pkg.sv
// Shared constants for the intra prediction residual/SAD path: default geometry,
// mode indices and the SAD accumulator width helper.
package intra_pred_pkg;

  localparam int unsigned DEF_BLK       = 8;
  localparam int unsigned DEF_BIT_DEPTH = 8;

  localparam int unsigned MODE_V  = 0;
  localparam int unsigned MODE_H  = 1;
  localparam int unsigned MODE_DC = 2;

  // Wide enough for BLK*BLK samples of |res| <= 2^bd - 1.
  function automatic int unsigned sad_width(input int unsigned bd, input int unsigned blk);
    return bd + 2 * $clog2(blk);
  endfunction

endpackage

// File: rtl/intra_row_sad.sv
// One mode's row: full-precision signed residuals (mb - pred) and the row sum of
// absolute residuals. Purely combinational.
module intra_row_sad #(
  parameter int unsigned BLK       = 8,
  parameter int unsigned BIT_DEPTH = 8,
  parameter int unsigned SADW      = 14
) (
  input  logic [BLK*BIT_DEPTH-1:0]     mb,
  input  logic [BLK*BIT_DEPTH-1:0]     pred,
  output logic [BLK*(BIT_DEPTH+1)-1:0] res,
  output logic [SADW-1:0]              row_sad
);

  localparam int unsigned RW = BIT_DEPTH + 1;

  logic [RW-1:0] diff [BLK];
  logic [RW-1:0] mag  [BLK];

  always_comb begin
    res     = '0;
    row_sad = '0;
    for (int p = 0; p < BLK; p++) begin
      // Zero-extended subtraction never wraps: result spans -(2^BD-1)..+(2^BD-1).
      diff[p] = {1'b0, mb[p*BIT_DEPTH +: BIT_DEPTH]} - {1'b0, pred[p*BIT_DEPTH +: BIT_DEPTH]};
      mag[p]  = diff[p][RW-1] ? (~diff[p] + RW'(1)) : diff[p];
      res[p*RW +: RW] = diff[p];
      row_sad = row_sad + SADW'(mag[p]);
    end
  end

endmodule

// File: rtl/intra_res_sad.sv
// Streaming residual generator with per-mode block SAD and best-mode selection.
// Optional build macro INTRA_RES_MODE_MASK_EN adds a per-block mode eligibility mask.
module intra_res_sad
  import intra_pred_pkg::*;
#(
  parameter int unsigned BLK       = DEF_BLK,
  parameter int unsigned BIT_DEPTH = DEF_BIT_DEPTH,
  parameter int unsigned NMODES    = 3
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [BLK*BIT_DEPTH-1:0]                   mb_row,
  input  logic [NMODES*BLK*BIT_DEPTH-1:0]            pred_row,
  output logic                                       res_valid,
  input  logic                                       res_ready,
  output logic [NMODES*BLK*(BIT_DEPTH+1)-1:0]        res_row,
  output logic [$clog2(BLK)-1:0]                     res_row_idx,
  output logic                                       res_last,
  output logic                                       sad_valid,
  output logic [NMODES*sad_width(BIT_DEPTH,BLK)-1:0] sad,
  output logic [$clog2(NMODES)-1:0]                  best_mode
`ifdef INTRA_RES_MODE_MASK_EN
  ,
  input  logic [NMODES-1:0]                          mode_mask
`endif
);

  localparam int unsigned IW   = $clog2(BLK);
  localparam int unsigned MW   = $clog2(NMODES);
  localparam int unsigned SADW = sad_width(BIT_DEPTH, BLK);
  localparam int unsigned RROW = BLK * (BIT_DEPTH + 1);
  localparam int unsigned PROW = BLK * BIT_DEPTH;

  logic [NMODES*RROW-1:0] row_res;
  logic [SADW-1:0]        row_sad [NMODES];
  logic [SADW-1:0]        acc_q   [NMODES];
  logic [SADW-1:0]        fin     [NMODES];
  logic [IW-1:0]          cnt_q;
  logic                   res_valid_q, sad_valid_q;
  logic [NMODES*RROW-1:0] res_row_q;
  logic [IW-1:0]          idx_q;
  logic [NMODES*SADW-1:0] sad_q;
  logic [MW-1:0]          best_q, best_d;
  logic [NMODES-1:0]      elig;
  logic                   accept, last_in;

  for (genvar m = 0; m < NMODES; m++) begin : g_mode
    intra_row_sad #(
      .BLK       (BLK),
      .BIT_DEPTH (BIT_DEPTH),
      .SADW      (SADW)
    ) u_row_sad (
      .mb      (mb_row),
      .pred    (pred_row[m*PROW +: PROW]),
      .res     (row_res[m*RROW +: RROW]),
      .row_sad (row_sad[m])
    );
  end

  assign in_ready = !res_valid_q || res_ready;
  assign accept   = in_valid && in_ready;
  assign last_in  = (cnt_q == IW'(BLK - 1));

`ifdef INTRA_RES_MODE_MASK_EN
  logic [NMODES-1:0] mask_q;
  // Row 0 sees the live mask; later rows use the copy captured at row 0.
  assign elig = (cnt_q == '0) ? mode_mask : mask_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '1;
    end else if (accept && cnt_q == '0) begin
      mask_q <= mode_mask;
    end
  end
`else
  assign elig = '1;
`endif

  // Block totals including the row being accepted; minimum search, ties to lowest index.
  always_comb begin
    logic            found;
    logic [SADW-1:0] best_val;
    found    = 1'b0;
    best_val = '0;
    best_d   = '0;
    for (int m = 0; m < NMODES; m++) begin
      fin[m] = acc_q[m] + row_sad[m];
      if (elig[m] && (!found || fin[m] < best_val)) begin
        found    = 1'b1;
        best_val = fin[m];
        best_d   = MW'(m);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_row_q   <= '0;
      idx_q       <= '0;
      sad_valid_q <= 1'b0;
      sad_q       <= '0;
      best_q      <= '0;
      for (int m = 0; m < NMODES; m++) acc_q[m] <= '0;
    end else begin
      sad_valid_q <= 1'b0;
      if (accept) begin
        res_valid_q <= 1'b1;
        res_row_q   <= row_res;
        idx_q       <= cnt_q;
        cnt_q       <= cnt_q + IW'(1);
        if (last_in) begin
          for (int m = 0; m < NMODES; m++) begin
            sad_q[m*SADW +: SADW] <= fin[m];
            acc_q[m]              <= '0;
          end
          best_q      <= best_d;
          sad_valid_q <= 1'b1;
        end else begin
          for (int m = 0; m < NMODES; m++) acc_q[m] <= fin[m];
        end
      end else if (res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign res_valid   = res_valid_q;
  assign res_row     = res_row_q;
  assign res_row_idx = idx_q;
  assign res_last    = (idx_q == IW'(BLK - 1));
  assign sad_valid   = sad_valid_q;
  assign sad         = sad_q;
  assign best_mode   = best_q;

endmodule

// File: doc/intra_res_sad.md
Name: intra_res_sad

Overview:
- Streaming, parametrised successor to the chroma 8x8 residual stage.
- Accepts one BLK-pixel row per beat: source block plus NMODES candidate prediction rows.
- Emits full-precision signed residual rows for every mode over a valid/ready handshake.
- Accumulates per-mode SAD over the block, then reports all SADs and the best mode to the mode-decision stage.

Parameters:
- BLK, 8, block edge in pixels (power of 2, 4..16); one row per beat, BLK rows per block.
- BIT_DEPTH, 8, sample width.
- NMODES, 3, number of prediction candidates (0=V, 1=H, 2=DC by convention).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  source/prediction row present.
- in_ready  out  1  row accepted when in_valid && in_ready.
- mb_row  in  BLK*BIT_DEPTH  source row; pixel p at [p*BIT_DEPTH +: BIT_DEPTH].
- pred_row  in  NMODES*BLK*BIT_DEPTH  mode m, pixel p at [(m*BLK+p)*BIT_DEPTH +: BIT_DEPTH].
- res_valid  out  1  residual row valid.
- res_ready  in  1  downstream accepts residual row.
- res_row  out  NMODES*BLK*(BIT_DEPTH+1)  signed two's-complement residuals, same packing as pred_row.
- res_row_idx  out  $clog2(BLK)  row index of res_row.
- res_last  out  1  res_row is row BLK-1.
- sad_valid  out  1  one-cycle pulse: block SADs ready.
- sad  out  NMODES*SADW  per-mode SAD; SADW = BIT_DEPTH + 2*$clog2(BLK).
- best_mode  out  $clog2(NMODES)  index of minimum SAD.

Behaviour:
- Reset: res_valid=0, sad_valid=0, res_row=0, res_row_idx=0, res_last=0, sad=0, best_mode=0; row counter and accumulators cleared. A reset mid-block abandons the partial block; the next accepted row is row 0.
- Residual: res = {1'b0,mb} - {1'b0,pred}, BIT_DEPTH+1 bits, no wrap. Range is -(2^BD-1)..+(2^BD-1).
- Output register: single stage. in_ready = !res_valid || res_ready, combinational. On acceptance, res_* load in the next cycle; latency is 1 cycle. res_* are held stable while res_valid && !res_ready.
- Row counter: 0..BLK-1, advances on acceptance and wraps to 0 after BLK-1. res_last = (res_row_idx==BLK-1).
- SAD: per-mode accumulator adds the row SAD (sum of |res|) on each acceptance. On acceptance of row BLK-1:
  - sad <= acc + row_sad; accumulators clear to 0 in the same edge.
  - sad_valid pulses the next cycle, coincident with the first cycle that last-row res_valid is high; the pulse is independent of res_ready.
- best_mode: computed combinationally from the final sums, registered with sad. Ties resolve to the lowest index.
- sad and best_mode hold until the next block completes.
- Back-to-back blocks: row 0 of the next block may be accepted the cycle after row BLK-1; no bubble is required.

Optional Feature:
- Macro INTRA_RES_MODE_MASK_EN adds input mode_mask[NMODES-1:0] (1 = mode allowed), sampled on acceptance of row 0 and held for the block.
- With the macro: masked modes are excluded from best_mode, but their sad is still reported. If all modes are masked, best_mode=0.
- Without the macro: all modes are eligible.

Decomposition:
- Package intra_pred_pkg holds:
  - default BLK and BIT_DEPTH;
  - mode index constants MODE_V=0, MODE_H=1, MODE_DC=2;
  - function sad_width(bd, blk).
- Sub-module intra_row_sad: combinational |a-b| and adder tree for one mode's row, instantiated NMODES times.

Test Plan:
- mb=100, V pred=90, H pred=110, DC pred=100, 8 rows -> res rows V=+10, H=-10 (9'h1F6), DC=0; sad=640/640/0; best_mode=2; one sad_valid pulse.
- mb=0, V pred=255, others=0 -> V residual -255 (9'h101); sad_V=16320 (fits 14 bits); best_mode=1 (tie H/DC, lowest index).
- res_ready held low 3 cycles while row 4 is pending -> in_ready low, no row lost or duplicated, res_row_idx sequence 0..7 intact.
- reset asserted after 3 rows accepted -> all outputs zero next cycle; following full block yields correct SADs from row 0.
- Two blocks back-to-back with continuous in_valid and res_ready=1 -> 16 consecutive accepts, two sad_valid pulses 8 cycles apart.
- INTRA_RES_MODE_MASK_EN, mask=3'b011 on the first scenario -> best_mode=0 (V/H tie at 640), sad_DC still reported as 0.
